// File: rtl/serial_pkg.sv
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the MSB-first serial pair serializer.
//                Holds the two-state FSM encoding used by the serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    // IDLE  : no word held, ready to accept a new operand pair
    // SHIFT : a word is being emitted one bit pair per consumed beat
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : serial_pkg

`default_nettype wire

// File: rtl/serial_pair_serializer_msb_first_if.sv
// ============================================================================
//  Module      : serial_pair_serializer_msb_first_if
//  Description : Handshake bundle between a parallel operand source, the
//                serializer and a serial bit-pair sink.
//  Ports       : in_valid/in_ready/in_a/in_b  - parallel operand pair handshake
//                out_valid/out_ready          - serial bit-pair handshake
//                a/b                          - current bits, MSB first
//                first/last                   - MSB / LSB markers of the word
//                master : environment side (drives operands and out_ready)
//                slave  : serializer side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_pair_serializer_msb_first_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             a;
    logic             b;
    logic             first;
    logic             last;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  a,
        input  b,
        input  first,
        input  last
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output a,
        output b,
        output first,
        output last
    );

endinterface : serial_pair_serializer_msb_first_if

`default_nettype wire

// File: rtl/serial_pair_serializer_msb_first.sv
// ============================================================================
//  Module      : serial_pair_serializer_msb_first
//  Description : Accepts a parallel operand pair (A, B) and emits it as a
//                stream of bit pairs, MSB first, with first/last markers.
//                Back-to-back words are emitted without a bubble.
//  Ports       : clk  - clock, all state changes on its rising edge
//                rst  - synchronous active-low reset
//                bus  - slave modport of serial_pair_serializer_msb_first_if
//  Parameters  : WIDTH - bits per operand (1..32)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_pair_serializer_msb_first
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst,
    serial_pair_serializer_msb_first_if.slave         bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    // Bits still to come after the MSB that is presented at acceptance.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             LAST_ON_LOAD = (WIDTH == 1);

    state_t           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [CNT_W-1:0] remaining;
    logic             out_valid_q;
    logic             a_q;
    logic             b_q;
    logic             first_q;
    logic             last_q;

    logic             consume;
    logic             ready_c;
    logic             accept;

    assign consume = out_valid_q & bus.out_ready;

    // Ready in IDLE, or in SHIFT on the very beat the LSB leaves, so the next
    // word can follow without a gap. Forced low while reset is asserted.
    always_comb begin
        ready_c = 1'b0;
        if (rst) begin
            case (state)
                IDLE:    ready_c = 1'b1;
                SHIFT:   ready_c = last_q & consume;
                default: ready_c = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid & ready_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            shift_a     <= '0;
            shift_b     <= '0;
            remaining   <= '0;
            out_valid_q <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else if (accept) begin
            // The MSB goes straight to the output registers; the shift
            // registers hold the remaining bits left-aligned.
            state       <= SHIFT;
            out_valid_q <= 1'b1;
            a_q         <= bus.in_a[WIDTH-1];
            b_q         <= bus.in_b[WIDTH-1];
            first_q     <= 1'b1;
            last_q      <= LAST_ON_LOAD;
            shift_a     <= bus.in_a << 1;
            shift_b     <= bus.in_b << 1;
            remaining   <= CNT_LOAD;
        end else if (consume) begin
            if (last_q) begin
                state       <= IDLE;
                out_valid_q <= 1'b0;
                a_q         <= 1'b0;
                b_q         <= 1'b0;
                first_q     <= 1'b0;
                last_q      <= 1'b0;
            end else begin
                a_q     <= shift_a[WIDTH-1];
                b_q     <= shift_b[WIDTH-1];
                first_q <= 1'b0;
                last_q  <= (remaining == CNT_ONE);
                shift_a <= shift_a << 1;
                shift_b <= shift_b << 1;
                if (remaining != '0) begin
                    remaining <= remaining - CNT_ONE;
                end
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.first     = first_q;
    assign bus.last      = last_q;

endmodule : serial_pair_serializer_msb_first

`default_nettype wire

// File: tb/tb_serial_pair_serializer_msb_first.sv
// ============================================================================
//  Module      : tb_serial_pair_serializer_msb_first
//  Description : Self-checking bench for serial_pair_serializer_msb_first.
//                Drives a WIDTH=8 and a WIDTH=1 instance; each has a queue of
//                pending bit pairs that is filled from every accepted word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_pair_serializer_msb_first;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    serial_pair_serializer_msb_first_if #(.WIDTH(8)) bus8 ();
    serial_pair_serializer_msb_first_if #(.WIDTH(1)) bus1 ();

    serial_pair_serializer_msb_first #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_pair_serializer_msb_first #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    pair_t q8[$];
    pair_t q1[$];
    int    total = 0;
    int    bad   = 0;
    logic  acc8;
    logic  acc1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push8(input logic [7:0] wa, input logic [7:0] wb);
        pair_t p;
        for (int k = 0; k < 8; k++) begin
            p.a     = wa[7-k];
            p.b     = wb[7-k];
            p.first = (k == 0);
            p.last  = (k == 7);
            q8.push_back(p);
        end
    endtask

    task automatic push1(input logic wa, input logic wb);
        pair_t p;
        p.a = wa; p.b = wb; p.first = 1'b1; p.last = 1'b1;
        q1.push_back(p);
    endtask

    // One clock: drive inputs, check in_ready mid-cycle, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic step(input logic rv, input logic v8, input logic v1, input logic ordy,
                        input logic [7:0] wa, input logic [7:0] wb);
        logic rdy8, rdy1, cons8, cons1;
        rst            = rv;
        bus8.in_valid  = v8;
        bus8.in_a      = wa;
        bus8.in_b      = wb;
        bus8.out_ready = ordy;
        bus1.in_valid  = v1;
        bus1.in_a      = wa[0:0];
        bus1.in_b      = wb[0:0];
        bus1.out_ready = ordy;
        @(negedge clk);
        rdy8  = rv && (q8.size() == 0 || (q8.size() == 1 && ordy));
        rdy1  = rv && (q1.size() == 0 || (q1.size() == 1 && ordy));
        chk("in_ready8", bus8.in_ready, rdy8);
        chk("in_ready1", bus1.in_ready, rdy1);
        acc8  = v8 && rdy8;
        acc1  = v1 && rdy1;
        cons8 = (q8.size() > 0) && ordy;
        cons1 = (q1.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (!rv) begin
            q8.delete();
            q1.delete();
        end else begin
            if (cons8) void'(q8.pop_front());
            if (cons1) void'(q1.pop_front());
            if (acc8) push8(wa, wb);
            if (acc1) push1(wa[0], wb[0]);
        end
        chk("out_valid8", bus8.out_valid, q8.size() > 0);
        chk("out_valid1", bus1.out_valid, q1.size() > 0);
        if (q8.size() > 0) chk("bits8", {bus8.a, bus8.b, bus8.first, bus8.last}, q8[0]);
        if (q1.size() > 0) chk("bits1", {bus1.a, bus1.b, bus1.first, bus1.last}, q1[0]);
        if (!rv) begin
            chk("rst_zero8", {bus8.out_valid, bus8.a, bus8.b, bus8.first, bus8.last}, 5'b0);
            chk("rst_zero1", {bus1.out_valid, bus1.a, bus1.b, bus1.first, bus1.last}, 5'b0);
        end
    endtask

    initial begin
        logic [7:0]  cap_a, cap_b, fmask, lmask, wa, wb;
        logic        gt, decided;
        logic [3:0]  snap;
        logic [31:0] fpos;
        int          nacc, run;
        logic        gap, rv, v8, v1, ordy;

        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        // 0x64 / 0x62 with a downstream MSB-first comparator
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h64, 8'h62);
        cap_a = '0; cap_b = '0; fmask = '0; lmask = '0; gt = 1'b0; decided = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cap_a = {cap_a[6:0], bus8.a};
            cap_b = {cap_b[6:0], bus8.b};
            fmask[k] = bus8.first;
            lmask[k] = bus8.last;
            if (bus8.first) begin
                decided = 1'b0;
                gt      = 1'b0;
            end
            if (!decided && (bus8.a != bus8.b)) begin
                decided = 1'b1;
                gt      = bus8.a;
            end
            chk("cmp_a_gt_b", gt, (k >= 5));
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        end
        chk("word_a_64", cap_a, 8'h64);
        chk("word_b_62", cap_b, 8'h62);
        chk("first_pos", fmask, 8'h01);
        chk("last_pos", lmask, 8'h80);

        // Two words back-to-back with in_valid held
        nacc = 0; run = 0; gap = 1'b0; fpos = '0;
        for (int i = 0; i < 22; i++) begin
            if (nacc < 2)
                step(1'b1, 1'b1, 1'b0, 1'b1, (nacc == 0) ? 8'hFF : 8'h01, (nacc == 0) ? 8'h00 : 8'h01);
            else
                step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
            if (acc8) nacc++;
            if (bus8.out_valid && !gap) begin
                if (bus8.first) fpos[run] = 1'b1;
                run++;
            end else if (run > 0) begin
                gap = 1'b1;
            end
        end
        chk("b2b_run_len", run, 16);
        chk("b2b_first_pos", fpos, 32'h0000_0101);

        // Stall three cycles on bit 3 of 0xA5 / 0x5A
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h5A);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        snap = {bus8.a, bus8.b, bus8.first, bus8.last};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
            chk("stall_hold", {bus8.a, bus8.b, bus8.first, bus8.last}, snap);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        chk("resume_bit4", {bus8.a, bus8.b}, 2'b01);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        // Reset in the middle of a word
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h3C);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        chk("post_rst_idle", bus8.out_valid, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h9E, 8'hE9);
        chk("post_rst_first", {bus8.a, bus8.b, bus8.first}, 3'b111);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        // WIDTH=1: two single-bit words back-to-back
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
        chk("w1_pair0", {bus1.a, bus1.b, bus1.first, bus1.last}, 4'b1011);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01);
        chk("w1_b2b_accept", acc1, 1'b1);
        chk("w1_pair1", {bus1.a, bus1.b, bus1.first, bus1.last}, 4'b0111);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        chk("w1_idle", bus1.out_valid, 1'b0);

        // Random traffic, occasional reset
        for (int i = 0; i < 600; i++) begin
            rv   = ($urandom_range(0, 59) != 0);
            v8   = ($urandom_range(0, 3) != 0);
            v1   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            wa   = 8'($urandom);
            wb   = 8'($urandom);
            step(rv, v8, v1, ordy, wa, wb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_pair_serializer_msb_first

`default_nettype wire

// File: doc/serial_pair_serializer_msb_first.md
SERIAL_PAIR_SERIALIZER_MSB_FIRST -- requirements
Module: serial_pair_serializer_msb_first

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each parallel operand; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on posedge clk; low = reset.
REQ-004 in_valid  input  1  parallel operand pair offered.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 in_a  input  WIDTH  operand A, parallel.
REQ-007 in_b  input  WIDTH  operand B, parallel.
REQ-008 out_valid  output  1  serial bit pair on a/b is valid.
REQ-009 out_ready  input  1  downstream consumes the current bit pair.
REQ-010 a  output  1  current bit of A, MSB first.
REQ-011 b  output  1  current bit of B, MSB first.
REQ-012 first  output  1  current bit pair is the MSB of the word (downstream comparator restart marker).
REQ-013 last  output  1  current bit pair is the LSB of the word.

Function
REQ-014 A pair SHALL be accepted on a cycle where in_valid & in_ready are both 1.
REQ-015 The block SHALL run a two-state FSM: IDLE (no word held) and SHIFT (word being emitted).
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 On acceptance, the next cycle SHALL present out_valid=1, a=in_a[WIDTH-1], b=in_b[WIDTH-1], first=1; state SHALL become SHIFT.
REQ-018 Latency from acceptance to first bit SHALL be exactly 1 cycle.
REQ-019 A bit pair SHALL advance only on out_valid & out_ready; otherwise a, b, first, last SHALL hold unchanged.
REQ-020 Bit k of the word (k=0 MSB-side index) SHALL present in_a[WIDTH-1-k], in_b[WIDTH-1-k]; first=1 only for k=0; last=1 only for k=WIDTH-1.
REQ-021 A down-counter of width $clog2(WIDTH+1) SHALL track remaining bits; no wrap-around past zero.
REQ-022 in_ready SHALL be 1 in SHIFT only when last & out_valid & out_ready (back-to-back, no bubble).
REQ-023 Acceptance coinciding with the last bit consumption SHALL make the next cycle show the new word's MSB with first=1.
REQ-024 Last bit consumed with no acceptance SHALL return the FSM to IDLE with out_valid=0 next cycle.
REQ-025 WIDTH=1: the single bit pair SHALL carry first=1 and last=1 simultaneously.
REQ-026 in_a/in_b SHALL be sampled only at acceptance; later changes SHALL not affect the word in flight.
REQ-027 All outputs except in_ready SHALL be registered; in_ready is combinational from state, last, out_valid, out_ready.

Reset
REQ-028 While rst=0 at a posedge, next state SHALL be IDLE; out_valid, a, b, first, last SHALL be 0.
REQ-029 in_ready SHALL be 0 while rst=0.
REQ-030 Reset mid-word SHALL discard the word; no partial bits SHALL appear after rst returns to 1.

Structure
REQ-031 The FSM state enum (IDLE, SHIFT) SHALL live in shared package serial_pkg.
REQ-032 No sub-module required; two WIDTH-bit left-shift registers and the counter are inline.

Verification
REQ-033 WIDTH=8, in_a=8'h64, in_b=8'h62, out_ready=1 -> a=0,1,1,0,0,1,0,0; b=0,1,1,0,0,0,1,0; first on bit 0, last on bit 7.
REQ-034 Two pairs (8'hFF/8'h00, then 8'h01/8'h01), in_valid held -> 16 consecutive out_valid cycles, no gap, first at cycles 0 and 8.
REQ-035 out_ready=0 for 3 cycles at bit 3 of 8'hA5/8'h5A -> a/b/first/last frozen 3 cycles, then bit 4 resumes.
REQ-036 rst=0 at bit 4 of a word -> out_valid=0 next cycle; after release in_ready=1, next word starts with first=1.
REQ-037 WIDTH=1, pairs 1/0 then 0/1 back-to-back -> two cycles, each first=1, last=1, a/b = 1/0 then 0/1.
REQ-038 Chain with downstream MSB-first comparator on 8'h64/8'h62 -> comparator reports a_greater_b from bit 5 onward.
